pc_fetch_ctrl: RTL
==================

Name: pc_fetch_ctrl

Overview:
Fetch-stage controller sitting directly upstream of the PC adder. Owns the program-counter register, drives Pc_Out to the adder and consumes its Pc_Add_Out as the sequential next PC. Issues one-at-a-time instruction-memory requests and presents fetched instructions to decode through an IF/ID output register with valid/ready. Handles branch/jump redirects from EX, flushing wrong-path work.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
Pc_Out  output  32  current fetch PC, to PC adder
Pc_Add_Out  input  32  Pc_Out + 4, from PC adder
Branch_Taken  input  1  redirect request from EX, single-cycle pulse
Branch_Target  input  32  redirect target, valid with Branch_Taken
Imem_Req_Valid  output  1  instruction fetch request valid
Imem_Req_Ready  input  1  memory accepts request this cycle
Imem_Req_Addr  output  32  fetch address (= Pc_Out)
Imem_Rsp_Valid  input  1  response data valid, 1 cycle pulse
Imem_Rsp_Data  input  32  fetched instruction word
Instr_Valid  output  1  IF/ID register holds a valid instruction
Instr_Out  output  32  IF/ID instruction
Instr_Pc  output  32  PC of Instr_Out
Id_Ready  input  1  decode consumes Instr_Out when Instr_Valid & Id_Ready

Behaviour:
- Reset (rst=1 at edge): Pc_Out=RESET_PC, state=S_REQ, Instr_Valid=0, Instr_Out=32'h0000_0013 (NOP), Instr_Pc=0, internal Req_Pc=0. Imem_Req_Valid=0 while rst=1.
- Imem_Req_Addr is combinationally Pc_Out.
- States: S_REQ (may issue), S_RSP (one request outstanding), S_DROP (outstanding request is wrong-path).
- Issue condition in S_REQ: Imem_Req_Valid = !Branch_Taken & (!Instr_Valid | Id_Ready). Guarantees IF/ID slot is free when the response returns; only one request ever outstanding.
- S_REQ, Valid&Ready: Req_Pc<=Pc_Out, Pc_Out<=Pc_Add_Out, -> S_RSP. Valid&!Ready: hold; memory samples address only on Valid&Ready, so address may change between unaccepted cycles.
- S_RSP, Imem_Rsp_Valid & !Branch_Taken: Instr_Out<=Imem_Rsp_Data, Instr_Pc<=Req_Pc, Instr_Valid<=1, -> S_REQ. Earliest next request the following cycle; steady-state throughput 1 instr per 2 cycles with 1-cycle memory.
- S_DROP: on Imem_Rsp_Valid discard data, -> S_REQ.
- Branch_Taken (highest priority, any state): Pc_Out<=Branch_Target, Instr_Valid<=0 (flush IF/ID, overrides a same-cycle consume or load); no request issued that cycle. Next state: S_REQ from S_REQ; from S_RSP/S_DROP -> S_DROP unless Imem_Rsp_Valid same cycle (response discarded, -> S_REQ).
- Consume: Instr_Valid & Id_Ready & no load & no branch -> Instr_Valid<=0. Load and consume same cycle -> Instr_Valid stays 1 with new data.
- Instr_Out/Instr_Pc hold while Instr_Valid & !Id_Ready.
- PC arithmetic wraps modulo 2^32 (adder result used as-is, 32'hFFFF_FFFC -> 0).
- Branch_Target[1:0] are forced to 2'b00 when loaded.
- Imem_Rsp_Valid in S_REQ is illegal; ignored.

Optional Feature:
FETCH_MISALIGN_CHK_EN
- Defined: extra output Misalign_Err (1 bit, reset 0); pulses high for one cycle the cycle after a Branch_Taken whose Branch_Target[1:0]!=0. Redirect still occurs to the target with [1:0] cleared.
- Undefined: port absent, low bits silently cleared, no other change.

Decomposition:
- Package rv_fetch_pkg: fetch_state_t enum {S_REQ,S_RSP,S_DROP}, NOP_INSTR=32'h0000_0013, PC_STEP=4, XLEN=32.
- Sub-module if_id_reg: Instr_Valid/Instr_Out/Instr_Pc register with load, consume, flush inputs. PC+4 stays external via Pc_Out/Pc_Add_Out.

Test Plan:
- Reset RESET_PC=32'h100, memory always ready, 1-cycle response -> requests at 100,104,108 on cycles 1,3,5; Instr_Pc 100,104,108 with matching data; Instr_Valid=0 during reset.
- Id_Ready=0 with Instr_Valid=1 for 5 cycles -> no new request, Instr_Out stable; Id_Ready=1 -> consumed, next request issued same cycle.
- Imem_Req_Ready=0 for 3 cycles -> Imem_Req_Valid held, Pc_Out unchanged at 104; accepted 4th cycle -> Pc_Out 108.
- Branch_Taken target 32'h200 while in S_RSP for 104 -> response for 104 discarded, IF/ID flushed, next request 200, Instr_Pc 200.
- Branch_Taken same cycle as Imem_Rsp_Valid -> data dropped, Instr_Valid=0, next request at target; Pc_Out=32'hFFFF_FFFC fetch -> next Pc_Out 0.
- FETCH_MISALIGN_CHK_EN defined, target 32'h302 -> request at 300, Misalign_Err one-cycle pulse; undefined -> request at 300, no port.

Source files
------------

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage controller.
package rv_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RSP  = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  // Redirect targets are word-aligned by discarding the low two bits.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if_id_reg.sv
// IF/ID pipeline register: holds one fetched instruction and its PC for decode.
import rv_fetch_pkg::*;

module if_id_reg (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            consume,
  input  logic            flush,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  // Priority: flush beats load, load beats consume (load+consume keeps valid set).
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, issues one-at-a-time imem requests, feeds IF/ID.
// Optional macro FETCH_MISALIGN_CHK_EN adds the Misalign_Err output.
import rv_fetch_pkg::*;

module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  output logic [31:0]  Pc_Out,
  input  logic [31:0]  Pc_Add_Out,
  input  logic         Branch_Taken,
  input  logic [31:0]  Branch_Target,
  output logic         Imem_Req_Valid,
  input  logic         Imem_Req_Ready,
  output logic [31:0]  Imem_Req_Addr,
  input  logic         Imem_Rsp_Valid,
  input  logic [31:0]  Imem_Rsp_Data,
  output logic         Instr_Valid,
  output logic [31:0]  Instr_Out,
  output logic [31:0]  Instr_Pc,
  input  logic         Id_Ready,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic         Misalign_Err,
`endif
  output fetch_state_t Fetch_State
);

  // Handshake: a request transfers on a cycle where Imem_Req_Valid & Imem_Req_Ready;
  // the address is only sampled then. IF/ID hands off on Instr_Valid & Id_Ready.

  fetch_state_t state;
  logic [31:0]  req_pc;
  logic         fire;
  logic         load;

  // Only issue when the IF/ID slot will be free by the time the response lands.
  assign Imem_Req_Valid = !rst && (state == S_REQ) && !Branch_Taken &&
                          (!Instr_Valid || Id_Ready);
  assign Imem_Req_Addr  = Pc_Out;
  assign fire           = Imem_Req_Valid && Imem_Req_Ready;
  assign load           = (state == S_RSP) && Imem_Rsp_Valid && !Branch_Taken;
  assign Fetch_State    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_REQ;
      Pc_Out <= RESET_PC;
      req_pc <= '0;
    end else if (Branch_Taken) begin
      Pc_Out <= align_pc(Branch_Target);
      // An outstanding request becomes wrong-path unless its response is here now.
      if (state == S_REQ || Imem_Rsp_Valid) state <= S_REQ;
      else                                  state <= S_DROP;
    end else begin
      case (state)
        S_REQ: begin
          if (fire) begin
            req_pc <= Pc_Out;
            Pc_Out <= Pc_Add_Out;
            state  <= S_RSP;
          end
        end
        S_RSP, S_DROP: begin
          if (Imem_Rsp_Valid) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) Misalign_Err <= 1'b0;
    else     Misalign_Err <= Branch_Taken && (Branch_Target[1:0] != 2'b00);
  end
`endif

  if_id_reg u_if_id (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .consume    (Id_Ready),
    .flush      (Branch_Taken),
    .load_instr (Imem_Rsp_Data),
    .load_pc    (req_pc),
    .valid      (Instr_Valid),
    .instr      (Instr_Out),
    .pc         (Instr_Pc)
  );

endmodule
